// File: rtl/conv_pkg.sv
// Shared widths, row types and FSM states for the conv9 row accumulator.
// Also holds the shift-and-saturate helper used on the final window sum.
package conv_pkg;

    localparam int KERNEL       = 9;
    localparam int PIX_WIDTH    = 8;
    localparam int WEIGHT_WIDTH = 18;
    localparam int ACC_WIDTH    = 36;
    localparam int FRAC_BITS    = 8;
    localparam int OUT_WIDTH    = 16;

    // Zero-extended pixel (9b signed) times signed weight, then 9 of those summed.
    localparam int PROD_WIDTH = PIX_WIDTH + 1 + WEIGHT_WIDTH;
    localparam int SUM_WIDTH  = PROD_WIDTH + 4;

    localparam int OUT_MAX = 2 ** (OUT_WIDTH - 1) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_WIDTH - 1));

    typedef logic [KERNEL-1:0][WEIGHT_WIDTH-1:0] weight_row_t;
    typedef logic [KERNEL-1:0][PIX_WIDTH-1:0]    pixel_row_t;
    typedef logic [3:0]                          row_idx_t;
    typedef logic signed [PROD_WIDTH-1:0]        prod_t;
    typedef logic signed [SUM_WIDTH-1:0]         sum_t;
    typedef logic signed [ACC_WIDTH-1:0]         acc_t;
    typedef logic signed [OUT_WIDTH-1:0]         out_t;

    localparam row_idx_t LAST_ROW = row_idx_t'(KERNEL - 1);

    typedef enum logic [1:0] {
        EXPECT0,
        ACCUM,
        DISCARD
    } state_t;

    // Arithmetic shift floors toward minus infinity before clamping.
    function automatic out_t saturate(acc_t value);
        acc_t shifted;
        shifted = value >>> FRAC_BITS;
        if (shifted > acc_t'(OUT_MAX)) return out_t'(OUT_MAX);
        if (shifted < acc_t'(OUT_MIN)) return out_t'(OUT_MIN);
        return shifted[OUT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/conv9_row_dot.sv
// Two-stage row dot product: S1 registers the 9 tap products, S2 registers
// their sum; row tag and valid travel alongside.
module conv9_row_dot
    import conv_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  weight_row_t weight_row_in,
    input  pixel_row_t  pixel_row_in,
    input  row_idx_t    row_num_in,
    input  logic        data_valid_in,
    output sum_t        row_sum_out,
    output row_idx_t    row_num_out,
    output logic        row_valid_out
);

    prod_t    prod_q [KERNEL];
    row_idx_t s1_row_q;
    logic     s1_valid_q;
    sum_t     sum_d;
    sum_t     s2_sum_q;
    row_idx_t s2_row_q;
    logic     s2_valid_q;

    // NOTE: only the valid bits need reset; datapath registers are qualified
    // by them, so leaving the data unreset is safe and keeps the flops cheap.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= data_valid_in;
            s2_valid_q <= s1_valid_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, regardless of statement order.
    always_ff @(posedge clk_in) begin
        for (int t = 0; t < KERNEL; t++) begin
            prod_q[t] <= prod_t'($signed({1'b0, pixel_row_in[t]})) *
                         prod_t'($signed(weight_row_in[t]));
        end
        s1_row_q <= row_num_in;
        s2_sum_q <= sum_d;
        s2_row_q <= s1_row_q;
    end

    // NOTE: the accumulator variable gets its default before the loop, so the
    // combinational block can never infer a latch.
    always_comb begin
        sum_d = '0;
        for (int t = 0; t < KERNEL; t++) begin
            sum_d = sum_d + sum_t'(prod_q[t]);
        end
    end

    assign row_sum_out   = s2_sum_q;
    assign row_num_out   = s2_row_q;
    assign row_valid_out = s2_valid_q;

endmodule

// File: rtl/conv9_row_accumulator.sv
// Accumulates nine row dot products per window with sequence checking, then
// shifts, saturates and presents the result through a one-entry valid/ready register.
module conv9_row_accumulator
    import conv_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  weight_row_t weight_row_in,
    input  pixel_row_t  pixel_row_in,
    input  row_idx_t    row_num_in,
    input  logic        data_valid_in,
    output out_t        result_out,
    output logic        result_valid_out,
    input  logic        result_ready_in,
    output logic        seq_err_out,
    output logic        overrun_out
);

    sum_t     s2_sum;
    row_idx_t s2_row;
    logic     s2_valid;
    acc_t     row_ext;

    state_t   state_q, state_d;
    row_idx_t exp_q, exp_d;
    acc_t     acc_q, acc_d;
    acc_t     final_q, final_d;
    logic     emit_q, emit_d;
    logic     seq_err_q, seq_err_d;

    out_t     result_q;
    logic     result_valid_q;
    logic     overrun_q;

    conv9_row_dot u_dot (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .weight_row_in (weight_row_in),
        .pixel_row_in  (pixel_row_in),
        .row_num_in    (row_num_in),
        .data_valid_in (data_valid_in),
        .row_sum_out   (s2_sum),
        .row_num_out   (s2_row),
        .row_valid_out (s2_valid)
    );

    assign row_ext = acc_t'(s2_sum);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= EXPECT0;
            exp_q     <= '0;
            acc_q     <= '0;
            final_q   <= '0;
            emit_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            acc_q     <= acc_d;
            final_q   <= final_d;
            emit_q    <= emit_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        acc_d     = acc_q;
        final_d   = final_q;
        emit_d    = 1'b0;
        seq_err_d = seq_err_q;
        if (s2_valid) begin
            case (state_q)
                EXPECT0: begin
                    if (s2_row == '0) begin
                        acc_d   = row_ext;
                        exp_d   = row_idx_t'(1);
                        state_d = ACCUM;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = DISCARD;
                    end
                end
                ACCUM: begin
                    if (s2_row == exp_q) begin
                        if (s2_row == LAST_ROW) begin
                            final_d = acc_q + row_ext;
                            emit_d  = 1'b1;
                            state_d = EXPECT0;
                        end else begin
                            acc_d = acc_q + row_ext;
                            exp_d = exp_q + row_idx_t'(1);
                        end
                    end else if (s2_row == '0) begin
                        // A fresh row 0 abandons the broken window and starts over.
                        seq_err_d = 1'b1;
                        acc_d     = row_ext;
                        exp_d     = row_idx_t'(1);
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = DISCARD;
                    end
                end
                DISCARD: begin
                    if (s2_row == '0) begin
                        acc_d   = row_ext;
                        exp_d   = row_idx_t'(1);
                        state_d = ACCUM;
                    end
                end
                default: state_d = EXPECT0;
            endcase
        end
    end

    // A result may enter the register only if it is empty or being drained now.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else if (emit_q) begin
            if (!result_valid_q || result_ready_in) begin
                result_q       <= saturate(final_q);
                result_valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (result_ready_in) begin
            result_valid_q <= 1'b0;
        end
    end

    assign result_out       = result_q;
    assign result_valid_out = result_valid_q;
    assign seq_err_out      = seq_err_q;
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_conv9_row_accumulator.sv
// Self-checking bench: directed scenarios plus randomized windows against a
// window-level reference model of row sums, sequencing and saturation.
module tb_conv9_row_accumulator;
    import conv_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    weight_row_t weight_row_in = '0;
    pixel_row_t  pixel_row_in = '0;
    row_idx_t    row_num_in = '0;
    logic        data_valid_in = 1'b0;
    out_t        result_out;
    logic        result_valid_out;
    logic        result_ready_in = 1'b1;
    logic        seq_err_out;
    logic        overrun_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: next row expected (-1 = discarding), running sum.
    int     m_next = 0;
    longint m_acc = 0;
    bit     m_seq_err = 1'b0;
    longint exp_mem [512];
    int     n_exp = 0;
    int     rd_idx = 0;

    // Monitor-owned capture of every accepted result.
    longint got_mem  [512];
    time    got_time [512];
    int     n_got = 0;

    conv9_row_accumulator dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .weight_row_in    (weight_row_in),
        .pixel_row_in     (pixel_row_in),
        .row_num_in       (row_num_in),
        .data_valid_in    (data_valid_in),
        .result_out       (result_out),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .seq_err_out      (seq_err_out),
        .overrun_out      (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (rst_n_in && result_valid_out && result_ready_in && n_got < 512) begin
            got_mem[n_got]  <= longint'(result_out);
            got_time[n_got] <= $time;
            n_got <= n_got + 1;
        end
    end

    function automatic longint model_sat(longint a);
        longint v;
        v = a >>> FRAC_BITS;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_reset();
        m_next = 0;
        m_acc = 0;
        m_seq_err = 1'b0;
    endfunction

    function automatic void model_row(int tag, longint s);
        if (tag == 0) begin
            if (m_next > 0) m_seq_err = 1'b1;
            m_acc = s;
            m_next = 1;
        end else if (m_next > 0 && tag == m_next) begin
            m_acc = m_acc + s;
            if (tag == KERNEL - 1) begin
                exp_mem[n_exp] = model_sat(m_acc);
                n_exp++;
                m_next = 0;
            end else begin
                m_next++;
            end
        end else begin
            if (m_next >= 0) m_seq_err = 1'b1;
            m_next = -1;
        end
    endfunction

    task automatic send_row(input weight_row_t w, input pixel_row_t p, input int tag);
        longint s = 0;
        for (int t = 0; t < KERNEL; t++) s += longint'($signed(w[t])) * longint'(p[t]);
        weight_row_in = w;
        pixel_row_in  = p;
        row_num_in    = row_idx_t'(tag);
        data_valid_in = 1'b1;
        model_row(tag, s);
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
    endtask

    task automatic send_uniform(input int wv, input int pv, input int tag);
        weight_row_t w;
        pixel_row_t  p;
        for (int t = 0; t < KERNEL; t++) begin
            w[t] = WEIGHT_WIDTH'(wv);
            p[t] = PIX_WIDTH'(pv);
        end
        send_row(w, p, tag);
    endtask

    task automatic send_window(input int wv, input int pv);
        for (int r = 0; r < KERNEL; r++) send_uniform(wv, pv, r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Wait for all modelled results, then compare them in order with captures.
    task automatic drain_scoreboard(input string name, input int budget);
        int waited = 0;
        while (n_got < n_exp && waited < budget) begin
            idle(1);
            waited++;
        end
        if (n_got < n_exp) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results, required %0d", name, n_got, n_exp);
        end
        idle(4);
        for (int i = rd_idx; i < n_got; i++) begin
            checks++;
            if (i >= n_exp) begin
                errors++;
                $display("FAIL %s_unexpected: got result %0d, none required", name, got_mem[i]);
            end else if (got_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL %s_value[%0d]: got %0d, required %0d", name, i, got_mem[i], exp_mem[i]);
            end
        end
        if (n_got > n_exp) n_exp = n_got;
        rd_idx = n_exp;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (result_out !== '0 || result_valid_out !== 1'b0 || seq_err_out !== 1'b0 || overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%0d v=%b se=%b ov=%b, required all 0",
                     result_out, result_valid_out, seq_err_out, overrun_out);
        end
        idle(2);
        #2;
        rst_n_in = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        result_ready_in = 1'b1;
        send_window(256, 10);
        idle(2);
        checks++;
        if (result_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b two cycles after row 8, required 0", result_valid_out);
        end
        idle(1);
        checks++;
        if (result_valid_out !== 1'b1 || result_out !== 16'sd810) begin
            errors++;
            $display("FAIL basic_latency: got v=%b res=%0d three cycles after row 8, required v=1 res=810",
                     result_valid_out, result_out);
        end
        drain_scoreboard("basic", 30);
    endtask

    task automatic test_neg_saturation();
        send_window(-131072, 255);
        drain_scoreboard("neg_sat", 30);
        checks++;
        if (got_mem[n_got-1] !== -64'sd32768) begin
            errors++;
            $display("FAIL neg_sat_value: got %0d, required -32768", got_mem[n_got-1]);
        end
        checks++;
        if (seq_err_out !== 1'b0 || overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL neg_sat_flags: got se=%b ov=%b, required 0 0", seq_err_out, overrun_out);
        end
    endtask

    task automatic test_back_to_back();
        int base = n_got;
        for (int k = 0; k < 2 * KERNEL; k++) send_uniform(256, 10, k % KERNEL);
        drain_scoreboard("b2b", 40);
        checks++;
        if (n_got - base != 2 || got_time[base+1] - got_time[base] != 90) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d results, spacing %0t, required 2 results 90 apart",
                     n_got - base, got_time[base+1] - got_time[base]);
        end
        checks++;
        if (overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b, required 0", overrun_out);
        end
    endtask

    task automatic test_seq_err();
        send_uniform(256, 10, 0);
        send_uniform(256, 10, 1);
        send_uniform(256, 10, 2);
        send_uniform(256, 10, 5);
        idle(2);
        send_window(256, 10);
        drain_scoreboard("seq_err", 30);
        checks++;
        if (seq_err_out !== m_seq_err || m_seq_err !== 1'b1) begin
            errors++;
            $display("FAIL seq_err_flag: got %b, required %b", seq_err_out, m_seq_err);
        end
    endtask

    task automatic test_overrun();
        result_ready_in = 1'b0;
        send_window(256, 10);
        send_window(512, 10);
        idle(6);
        checks++;
        if (result_valid_out !== 1'b1 || result_out !== 16'sd810 || overrun_out !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold: got v=%b res=%0d ov=%b, required v=1 res=810 ov=1",
                     result_valid_out, result_out, overrun_out);
        end
        n_exp--;
        result_ready_in = 1'b1;
        drain_scoreboard("overrun", 10);
        checks++;
        if (result_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL overrun_consume: got v=%b after consume, required 0", result_valid_out);
        end
    endtask

    task automatic test_reset_mid_window();
        weight_row_t w;
        pixel_row_t  p;
        for (int r = 0; r < 4; r++) send_uniform(256, 10, r);
        for (int t = 0; t < KERNEL; t++) begin
            w[t] = WEIGHT_WIDTH'(256);
            p[t] = PIX_WIDTH'(10);
        end
        weight_row_in = w;
        pixel_row_in  = p;
        row_num_in    = 4'd4;
        data_valid_in = 1'b1;
        #3;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (result_valid_out !== 1'b0 || seq_err_out !== 1'b0 || overrun_out !== 1'b0 || result_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got res=%0d v=%b se=%b ov=%b, required all 0",
                     result_out, result_valid_out, seq_err_out, overrun_out);
        end
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        idle(1);
        #2;
        rst_n_in = 1'b1;
        model_reset();
        idle(1);
        send_window(256, 10);
        drain_scoreboard("midreset", 30);
        checks++;
        if (seq_err_out !== 1'b0 || overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got se=%b ov=%b, required 0 0", seq_err_out, overrun_out);
        end
    endtask

    task automatic test_random();
        weight_row_t w;
        pixel_row_t  p;
        int          tag;
        bit          corrupt;
        int          bad_pos;
        result_ready_in = 1'b1;
        for (int win = 0; win < 30; win++) begin
            corrupt = ($urandom_range(0, 3) == 0);
            bad_pos = $urandom_range(0, KERNEL - 1);
            for (int r = 0; r < KERNEL; r++) begin
                for (int t = 0; t < KERNEL; t++) begin
                    w[t] = WEIGHT_WIDTH'($urandom);
                    p[t] = PIX_WIDTH'($urandom);
                end
                tag = (corrupt && r == bad_pos) ? int'($urandom_range(0, 15)) : r;
                send_row(w, p, tag);
                idle($urandom_range(0, 2));
            end
        end
        drain_scoreboard("random", 40);
        checks++;
        if (seq_err_out !== m_seq_err) begin
            errors++;
            $display("FAIL random_seq_err: got %b, required %b", seq_err_out, m_seq_err);
        end
        checks++;
        if (overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL random_overrun: got %b, required 0", overrun_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_saturation();
        test_back_to_back();
        test_seq_err();
        test_overrun();
        test_reset_mid_window();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
